// File: rtl/id_ctrl_if.sv
// id_ctrl_if: ID-stage to EX-stage control handshake bundle.
//   slave  : decode controller side (consumes the ID instruction, drives the ID/EX control)
//   master : surrounding pipeline side (fetch/IF-ID register and execute stage)
// Signals:
//   id_valid, id_instr  - ID-stage instruction and its qualifier
//   id_ready            - ID instruction is consumed this cycle (combinational)
//   ex_ready, flush     - EX back-pressure and redirect kill
//   ex_*                - registered ID/EX control bundle
//   div_busy            - mul/div issue interlock active
interface id_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [31:0]       id_instr;
    logic              id_ready;
    logic              ex_ready;
    logic              flush;
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_jump;
    logic              ex_mem_read;
    logic              ex_mem_to_reg;
    logic              ex_alu_src;
    logic              ex_reg_write;
    logic              ex_illegal;
    logic              ex_muldiv;
    logic [1:0]        ex_mem_write;
    logic [REG_AW-1:0] ex_rd;
    logic              div_busy;

    modport master (
        output id_valid, id_instr, ex_ready, flush,
        input  id_ready, ex_valid, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg,
               ex_alu_src, ex_reg_write, ex_illegal, ex_muldiv, ex_mem_write, ex_rd,
               div_busy
    );

    modport slave (
        input  id_valid, id_instr, ex_ready, flush,
        output id_ready, ex_valid, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg,
               ex_alu_src, ex_reg_write, ex_illegal, ex_muldiv, ex_mem_write, ex_rd,
               div_busy
    );
endinterface

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: RV32 ID-stage decode controller registered into the ID/EX boundary.
// Decodes the control bundle, detects load-use hazards over a LOAD_LAT-cycle window,
// kills ID and ID/EX on flush, and (optionally) interlocks issue behind a multi-cycle divide.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   bus      - id_ctrl_if.slave (ID instruction in, id_ready out, ID/EX control out)
// Parameters: REG_AW (5 = RV32I, 4 = RV32E), LOAD_LAT (1..3), DIV_CYCLES (2..64).
// Build option: define CTRL_MULDIV_EN to decode M-extension ops and enable the divide interlock;
// without it funct7=0000001 OP instructions decode as illegal and div_busy is tied low.
module id_ctrl_pipe #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst,
    id_ctrl_if.slave  bus
);

    localparam int unsigned LDW = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Parameter range guard, evaluated at elaboration.
    if (LOAD_LAT < 1 || LOAD_LAT > 3 || DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : g_bad_param
        $error("id_ctrl_pipe: LOAD_LAT or DIV_CYCLES out of range");
    end

    typedef struct packed {
        logic              branch;
        logic              jump;
        logic              mem_read;
        logic              mem_to_reg;
        logic              alu_src;
        logic              reg_write;
        logic              illegal;
        logic              muldiv;
        logic [1:0]        mem_write;
        logic [REG_AW-1:0] rd;
    } ctrl_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;

    ctrl_t             dec;
    logic              use_rs1;
    logic              use_rs2;
    logic              is_load;
    logic              is_div;

    ctrl_t             ex_q;
    logic              ex_valid_q;
    logic [LDW-1:0]    ld_cnt;
    logic [REG_AW-1:0] ld_rd;
    logic              div_busy_q;
    logic              hazard_c;
    logic              id_ready_c;

    assign opcode = bus.id_instr[6:0];
    assign funct3 = bus.id_instr[14:12];
    assign funct7 = bus.id_instr[31:25];
    assign rd_f   = bus.id_instr[7 +: REG_AW];
    assign rs1_f  = bus.id_instr[15 +: REG_AW];
    assign rs2_f  = bus.id_instr[20 +: REG_AW];

    // Instruction decode into the control bundle plus source-register usage.
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        is_load = 1'b0;
        is_div  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b0;
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b0;
            end
            OPC_JALR: begin
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_LOAD: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                is_load        = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_src = 1'b1;
                use_rs2     = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_write = 2'b01;
                    3'b001:  dec.mem_write = 2'b10;
                    3'b010:  dec.mem_write = 2'b11;
                    default: dec.illegal   = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                use_rs2 = 1'b1;
                if (funct7 == 7'b0000001) begin
`ifdef CTRL_MULDIV_EN
                    dec.reg_write = 1'b1;
                    dec.muldiv    = 1'b1;
                    is_div        = funct3[2];
`else
                    dec.illegal   = 1'b1;
`endif
                end else begin
                    dec.reg_write = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // x0 is never written; rd is only meaningful for writing instructions.
        if (rd_f == '0) begin
            dec.reg_write = 1'b0;
        end
        dec.rd = dec.reg_write ? rd_f : '0;
    end

    // Load-use hazard against the tracked in-flight load destination.
    always_comb begin
        hazard_c = 1'b0;
        if (ld_cnt != '0) begin
            hazard_c = (use_rs1 && (rs1_f == ld_rd)) || (use_rs2 && (rs2_f == ld_rd));
        end
    end

    assign id_ready_c  = bus.ex_ready && !hazard_c && !div_busy_q && !bus.flush;
    assign bus.id_ready = id_ready_c;

    // ID/EX register: flush > hold > bubble > advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else if (bus.flush) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else if (bus.ex_ready) begin
            if (hazard_c || div_busy_q) begin
                ex_q       <= '0;
                ex_valid_q <= 1'b0;
            end else begin
                ex_q       <= bus.id_valid ? dec : '0;
                ex_valid_q <= bus.id_valid;
            end
        end
    end

    // Load tracking: arm on a real load advancing with rd != 0, count down while EX moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            ld_rd  <= '0;
        end else if (bus.flush) begin
            ld_cnt <= '0;
        end else if (bus.ex_ready) begin
            if (id_ready_c && bus.id_valid && is_load && (rd_f != '0)) begin
                ld_cnt <= LDW'(LOAD_LAT);
                ld_rd  <= rd_f;
            end else if (ld_cnt != '0) begin
                ld_cnt <= ld_cnt - LDW'(1);
            end
        end
    end

`ifdef CTRL_MULDIV_EN
    localparam int unsigned DIVW = $clog2(DIV_CYCLES);

    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_cnt_d;

    // Divide occupancy counter; the busy flag is registered alongside it.
    always_comb begin
        div_cnt_d = div_cnt;
        if (bus.flush) begin
            div_cnt_d = '0;
        end else if (bus.ex_ready) begin
            if (id_ready_c && bus.id_valid && is_div) begin
                div_cnt_d = DIVW'(DIV_CYCLES - 1);
            end else if (div_cnt != '0) begin
                div_cnt_d = div_cnt - DIVW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            div_busy_q <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_d;
            div_busy_q <= (div_cnt_d != '0);
        end
    end
`else
    assign div_busy_q = 1'b0;
`endif

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_illegal    = ex_q.illegal;
    assign bus.ex_muldiv     = ex_q.muldiv;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.div_busy      = div_busy_q;

endmodule

// File: doc/id_ctrl_pipe.md
# id_ctrl_pipe

Parametrised decode controller for the pipelined RV32 core, registered into the ID/EX boundary. It decodes the ID-stage instruction into the control bundle: branch, jump, memory read/write size, write-back select, ALU source and register write. It also owns load-use hazard detection with a configurable memory latency, pipeline flush on redirect, and an optional multi-cycle mul/div issue interlock. It sits between the IF/ID register and the execute stage, and drives the `id_ready` back-pressure to fetch.

## Interface
- `REG_AW`, 5 — register address width; 5 for RV32I, 4 for RV32E (upper rd/rs bits ignored).
- `LOAD_LAT`, 1 — load-use stall window in cycles, 1..3.
- `DIV_CYCLES`, 32 — occupancy of a DIV/DIVU/REM/REMU in EX, 2..64.
---
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `id_valid` in 1 — ID holds a valid instruction.
- `id_instr` in 32 — instruction word.
- `ex_ready` in 1 — EX can accept; low holds the ID/EX register.
- `flush` in 1 — redirect from EX; kill ID and ID/EX contents.
- `id_ready` out 1 — combinational; ID instruction is consumed this cycle.
- `ex_valid` out 1 — ID/EX holds a real instruction (0 = bubble).
- `ex_branch`, `ex_jump`, `ex_mem_read`, `ex_mem_to_reg`, `ex_alu_src`, `ex_reg_write`, `ex_illegal`, `ex_muldiv` out 1 each — registered control.
- `ex_mem_write` out 2 — 00 idle, 01 byte, 10 half, 11 word.
- `ex_rd` out REG_AW — destination register.
- `div_busy` out 1 — mul/div interlock active.

## Operation
- Decode, standard RV32I opcodes:
  - LUI: alu_src, reg_write.
  - AUIPC: alu_src, reg_write.
  - JAL/JALR: jump, alu_src, reg_write.
  - BRANCH: branch.
  - LOAD: mem_read, mem_to_reg, alu_src, reg_write.
  - STORE: alu_src, mem_write from funct3 (000→01, 001→10, 010→11, else 00 plus illegal).
  - OP_IMM: alu_src, reg_write.
  - OP: reg_write.
  - Any other opcode: all zero, illegal=1.
- Source usage: rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used by BRANCH, STORE and OP.
- Load-use tracking:
  - When a LOAD with rd≠0 advances into EX, `ld_rd`←rd and `ld_cnt`←LOAD_LAT.
  - `ld_cnt` decrements each cycle `ex_ready`=1, saturating at 0.
- Hazard: `ld_cnt`≠0 and a used rs equals `ld_rd`.
- `id_ready` = `ex_ready` & ~hazard & ~`div_busy` & ~`flush`.
- Priority: flush > `ex_ready` low (hold all state) > hazard or div_busy (insert bubble) > advance (load decoded bundle, `ex_valid`=`id_valid`).
- Bubble: every ex_* output is 0.
- Flush: the next cycle has all ex_* outputs 0, `ld_cnt`=0 and the div counter = 0.
- x0 writes: rd=0 clears `ex_reg_write`. A load to x0 does not arm tracking.

## Timing
- Decode-to-`ex_*` latency is 1 cycle. `id_ready` is combinational from the inputs and the registered state.
- A consumer directly behind a load stalls exactly LOAD_LAT cycles. A consumer k instructions behind stalls max(0, LOAD_LAT−k).
- Reset (async, immediate): all ex_* outputs 0, `ld_cnt`=0, `div_busy`=0.
- Load advancing in the same cycle a flush asserts: flush wins, and tracking is not armed.
- `ex_ready` low during a stall: all counters freeze.

## Configuration
- `CTRL_MULDIV_EN` defined:
  - OP with funct7=0000001 decodes as reg_write plus `ex_muldiv`.
  - If funct3[2]=1 (div/rem), advancing it into EX loads the div counter with DIV_CYCLES−1.
  - `div_busy` is high while the counter ≠ 0; ID stalls and bubbles are inserted.
  - The counter decrements when `ex_ready`=1.
- Undefined:
  - funct7=0000001 gives illegal=1 and reg_write=0.
  - `ex_muldiv` and `div_busy` are tied 0.
  - No counter is instantiated.

## Test plan
- Reset mid-stream with `ld_cnt`=2 → all ex_* outputs 0 asynchronously; the first post-reset `sw x1,0(x2)` gives `ex_mem_write`=11, `ex_alu_src`=1, `ex_reg_write`=0.
- LOAD_LAT=1, `lw x5` then `add x6,x5,x7` → one bubble cycle (`id_ready`=0, `ex_valid`=0), then add issues; `lw x0` then add using x0 → no stall.
- LOAD_LAT=3, `lw x5`, nop, `beq x5,x1` → 2 stall cycles; `lui x5` behind the load → no stall (rs unused).
- flush asserted with a load in ID and `ld_cnt`=1 → next cycle `ex_valid`=0, `ld_cnt`=0, the following dependent add issues without a stall.
- `ex_ready` low 3 cycles during a hazard → ID/EX and `ld_cnt` frozen, stall resumes its remaining count afterward.
- With `CTRL_MULDIV_EN`, DIV_CYCLES=4, `div x3` then `add` → `div_busy` high 3 cycles, add issues on cycle 4; without the macro → `div` gives `ex_illegal`=1 and no stall.
